// File: rtl/accum_nbit_cout_if.sv
// accum_nbit_cout_if: input word stream and result stream of the accumulator.
//   in_valid/in_ready/in_data/in_last : word stream into the accumulator
//   out_valid/out_ready/out_sum/out_ovf_cnt/out_terms : per-packet result
//   master : producer/consumer side (drives words, accepts results)
//   slave  : accumulator side
interface accum_nbit_cout_if #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_sum;
  logic [CNT_WIDTH-1:0] out_ovf_cnt;
  logic [CNT_WIDTH-1:0] out_terms;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf_cnt, out_terms
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_ovf_cnt, out_terms
  );
endinterface

// File: rtl/accum_nbit_cout.sv
// accum_nbit_cout: packet accumulator closing the loop around an external
// combinational carry-out adder.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : word/result streams (slave modport)
//   add_a     : adder A operand = accumulator register
//   add_b     : adder B operand = in_data pass-through
//   add_sum   : adder Sum, loaded into the accumulator on accept
//   add_cout  : adder Cout, counted as a wrap-around on accept
module accum_nbit_cout #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  accum_nbit_cout_if.slave     bus,
  output logic [WIDTH-1:0]     add_a,
  output logic [WIDTH-1:0]     add_b,
  input  logic [WIDTH-1:0]     add_sum,
  input  logic                 add_cout
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [CNT_WIDTH-1:0] ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0] terms_q, terms_d;
  logic                 accept;

  // Outputs decode straight from registered state, so no combinational path
  // from in_valid/out_ready to in_ready/out_valid.
  assign bus.in_ready    = (state_q != HOLD);
  assign bus.out_valid   = (state_q == HOLD);
  assign bus.out_sum     = acc_q;
  assign bus.out_ovf_cnt = ovf_q;
  assign bus.out_terms   = terms_q;

  assign add_a  = acc_q;
  assign add_b  = bus.in_data;
  assign accept = bus.in_valid && bus.in_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    terms_d = terms_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          acc_d   = add_sum;
          // Both counters stick at all-ones rather than wrapping.
          if (add_cout && (ovf_q != CNT_MAX)) ovf_d = ovf_q + CNT_WIDTH'(1);
          if (terms_q != CNT_MAX)             terms_d = terms_q + CNT_WIDTH'(1);
          state_d = bus.in_last ? HOLD : ACCUM;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          // Clear here so the next packet's first word sees add_a = 0.
          acc_d   = '0;
          ovf_d   = '0;
          terms_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= '0;
      terms_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      terms_q <= terms_d;
    end
  end

endmodule

// File: doc/accum_nbit_cout.md
# accum_nbit_cout

Streaming accumulator that sits directly downstream of the n-bit carry-out adder and closes its feedback loop. It drives the adder's A operand with the running sum and the B operand with the incoming word, then registers the adder's Sum back into the accumulator. It also counts Cout events as wrap-arounds and emits one result per packet of input words over a valid/ready handshake. The adder stays purely combinational; all state lives here.

## Interface
- WIDTH, 32: data width; must match the adder WIDTH.
- CNT_WIDTH, 8: width of the term counter and the overflow counter.

- clk  input  1  sole clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data/in_last valid.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  WIDTH  operand to accumulate.
- in_last  input  1  marks final word of a packet.
- add_a  output  WIDTH  to adder A; equals current accumulator register.
- add_b  output  WIDTH  to adder B; equals in_data (pass-through, combinational).
- add_sum  input  WIDTH  adder Sum (combinational return path).
- add_cout  input  1  adder Cout.
- out_valid  output  1  result held and valid.
- out_ready  input  1  downstream accepts result.
- out_sum  output  WIDTH  final accumulator value, modulo 2^WIDTH.
- out_ovf_cnt  output  CNT_WIDTH  number of accepted words whose add produced Cout=1, saturating.
- out_terms  output  CNT_WIDTH  number of words accepted in the packet, saturating.

## Operation
- States: IDLE (acc=0, no terms), ACCUM (packet in progress), HOLD (result presented).
- in_ready = 1 in IDLE and ACCUM, 0 in HOLD.
- Accept = in_valid & in_ready.
  - On accept: acc <= add_sum; ovf <= ovf + add_cout; terms <= terms + 1.
  - Both counters saturate at 2^CNT_WIDTH-1 and never wrap.
- IDLE: accept with in_last=0 -> ACCUM; accept with in_last=1 -> HOLD (single-word packet).
- ACCUM: accept with in_last=1 -> HOLD; otherwise remain. Cycles with in_valid=0 leave state unchanged.
- HOLD: out_valid=1.
  - out_sum, out_ovf_cnt and out_terms are driven from the acc/ovf/terms registers and held stable while out_ready=0.
  - On out_valid & out_ready: acc, ovf and terms clear to 0 and state -> IDLE.
- Arithmetic: the sum is modulo 2^WIDTH. The true sum equals out_ovf_cnt*2^WIDTH + out_sum while out_ovf_cnt is unsaturated.
- in_data is ignored whenever in_ready=0. add_b always mirrors in_data regardless.
- No packet may be empty. in_last only takes effect with an accept.

## Timing
- Reset values: state=IDLE, acc=0, ovf=0, terms=0, out_valid=0, in_ready=1.
  - add_a=0 after reset; add_b follows in_data.
  - out_sum, out_ovf_cnt and out_terms all read 0.
- Throughput: one word per cycle within a packet. The adder path add_a -> add_sum -> acc is a single-cycle combinational loop through the adder.
- Latency: out_valid rises the cycle after the accept carrying in_last.
- HOLD lasts at least 1 cycle. in_ready is 0 during every HOLD cycle, including the handshake cycle, so there is a minimum one-cycle input bubble between packets.
- The first word of the next packet can be accepted the cycle after the out handshake, with acc already 0.
- rst asserted in any state, including mid-packet or in HOLD with out_ready=0, returns everything to reset values on the next edge. The pending result is discarded.
- Saturation boundary: a carry when ovf = 2^CNT_WIDTH-1 leaves ovf unchanged; the same applies to terms.

## Test plan
- WIDTH=8, CNT_WIDTH=4:
  - Packet 10, 20, 30 (last), out_ready=1 -> out_valid one cycle after 30, out_sum=60, ovf=0, terms=3, then IDLE.
  - Packet 200, 100 (last) -> out_sum=44, out_ovf_cnt=1, out_terms=2.
  - Single word 255 with in_last -> HOLD immediately, out_sum=255, ovf=0, terms=1.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD while in_valid=1 with new data -> in_ready=0, outputs stable, no word consumed. After the handshake the next packet starts from acc=0.
- Saturation: 20 words of 255 with CNT_WIDTH=4 -> out_terms=15, out_ovf_cnt=15, out_sum=(20*255) mod 256=236.
- Reset mid-packet after 10, 20 accepted, then rst for 1 cycle, then packet 5 (last) -> out_sum=5, terms=1.
- Random packets with random in_valid/out_ready against a scoreboard of true sums.
